// File: rtl/ffd_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, write data,
// the one-hot grant and the shared register view.
interface ffd_share_arbiter_if #(
    parameter int unsigned WD   = 2,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*WD-1:0] d;
    logic [NREQ-1:0]    gnt;
    logic [OW-1:0]      owner;
    logic [WD-1:0]      q;
    logic               q_valid;

    modport master (output req, d, input gnt, owner, q, q_valid);
    modport slave  (input req, d, output gnt, owner, q, q_valid);
endinterface

// File: rtl/ffd_share_arbiter.sv
// Round-robin arbiter sequencing bursts of writes from NREQ requesters into
// one shared WD-bit register; grants last at most MAX_HOLD writes.
module ffd_share_arbiter #(
    parameter int unsigned WD       = 2,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    ffd_share_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [HW-1:0]   hold;
    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   owner;
    logic [WD-1:0]   q;
    logic            q_valid;

    logic            pick_any;
    logic [OW-1:0]   pick_idx;
    logic            cur_req;
    logic [WD-1:0]   cur_d;
    logic [OW-1:0]   ptr_after;

    // First requester at or after ptr, searching cyclically; lowest offset wins.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % int'(NREQ);
            if (bus.req[idx]) begin
                pick_any = 1'b1;
                pick_idx = OW'(idx);
            end
        end
    end

    // Request and data slice of the current owner.
    always_comb begin
        cur_req = 1'b0;
        cur_d   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (OW'(i) == owner) begin
                cur_req = bus.req[i];
                cur_d   = bus.d[i*int'(WD) +: WD];
            end
        end
    end

    assign ptr_after = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            hold    <= '0;
            gnt     <= '0;
            owner   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= GRANT;
                        gnt   <= NREQ'(1) << pick_idx;
                        owner <= pick_idx;
                        hold  <= '0;
                    end
                end
                GRANT: begin
                    if (cur_req) begin
                        q       <= cur_d;
                        q_valid <= 1'b1;
                        hold    <= hold + HW'(1);
                    end
                    // Release on dropped request or when this write fills the burst.
                    if (!cur_req || hold == HW'(MAX_HOLD - 1)) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= ptr_after;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.owner   = owner;
    assign bus.q       = q;
    assign bus.q_valid = q_valid;
endmodule

// File: tb/tb_ffd_share_arbiter.sv
// Directed bench for ffd_share_arbiter: stimulus queues expected grants and
// writes, a negedge monitor pops and compares them as the DUT produces them.
module tb_ffd_share_arbiter;
    localparam int unsigned WD       = 2;
    localparam int unsigned NREQ     = 4;

    logic clk;
    logic reset;

    ffd_share_arbiter_if #(.WD(WD), .NREQ(NREQ)) bus ();

    ffd_share_arbiter #(.WD(WD), .NREQ(NREQ), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int         gq[$];   // expected owner index of each new grant
    logic [3:0] wq[$];   // expected {owner, q} of each write

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_d(input int i, input logic [1:0] v);
        bus.d[i*2 +: 2] = v;
    endtask

    task automatic exp_wr(input int o, input logic [1:0] v, input int n);
        for (int k = 0; k < n; k++) wq.push_back({2'(o), v});
    endtask

    // Monitor: checks every write and every new grant against the queues.
    initial begin
        logic [3:0] prev_gnt;
        logic [3:0] e;
        int         g;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_gnt = '0;
            end else begin
                chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
                if (bus.q_valid) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 32'(bus.q_valid), 32'd0);
                    end else begin
                        e = wq.pop_front();
                        chk("write_q", 32'(bus.q), 32'(e[1:0]));
                        chk("write_owner", 32'(bus.owner), 32'(e[3:2]));
                    end
                end
                if (bus.gnt != '0 && prev_gnt == '0) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", 32'(bus.gnt), 32'd0);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_owner", 32'(bus.owner), 32'(g));
                        chk("grant_onehot", 32'(bus.gnt), 32'd1 << g);
                    end
                end
                prev_gnt = bus.gnt;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        bus.req = '0;
        bus.d   = '0;
        repeat (2) tick();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_qv", 32'(bus.q_valid), 32'd0);
        reset = 1'b0;

        // Single requester 2: full burst, turnaround, re-grant, early drop.
        bus.req = 4'b0100;
        set_d(2, 2'b01);
        gq.push_back(2);
        exp_wr(2, 2'b01, 1); exp_wr(2, 2'b10, 1); exp_wr(2, 2'b11, 1); exp_wr(2, 2'b00, 1);
        tick(); chk("a_gnt1", 32'(bus.gnt), 32'b0100);
        tick(); chk("a_gnt2", 32'(bus.gnt), 32'b0100); set_d(2, 2'b10);
        tick(); chk("a_gnt3", 32'(bus.gnt), 32'b0100); set_d(2, 2'b11);
        tick(); chk("a_gnt4", 32'(bus.gnt), 32'b0100); set_d(2, 2'b00);
        tick(); chk("a_turn", 32'(bus.gnt), 32'd0);
        gq.push_back(2);
        tick(); chk("a_regnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        tick(); chk("a_rel", 32'(bus.gnt), 32'd0);
        chk("a_rel_qv", 32'(bus.q_valid), 32'd0);
        chk("a_rel_q", 32'(bus.q), 32'b00);

        // Asynchronous reset in the middle of a burst from requester 1.
        bus.req = 4'b0010;
        set_d(1, 2'b11);
        gq.push_back(1);
        exp_wr(1, 2'b11, 1);
        tick(); chk("r_gnt", 32'(bus.gnt), 32'b0010);
        tick(); chk("r_q", 32'(bus.q), 32'b11);
        #2 reset = 1'b1; bus.req = '0;
        #1;
        chk("r_async_gnt", 32'(bus.gnt), 32'd0);
        chk("r_async_q", 32'(bus.q), 32'd0);
        chk("r_async_qv", 32'(bus.q_valid), 32'd0);
        chk("r_async_owner", 32'(bus.owner), 32'd0);
        tick();
        reset = 1'b0;
        bus.req = 4'b0100;
        set_d(2, 2'b10);
        gq.push_back(2);
        tick(); chk("r_after_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        tick(); chk("r_after_rel", 32'(bus.gnt), 32'd0);
        chk("r_after_q", 32'(bus.q), 32'd0);

        // Round robin from reset with every requester asserting.
        reset = 1'b1;
        tick();
        bus.req = 4'b1111;
        bus.d   = 8'b11_10_01_00;
        reset = 1'b0;
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
        exp_wr(0, 2'd0, 4); exp_wr(1, 2'd1, 4); exp_wr(2, 2'd2, 4); exp_wr(3, 2'd3, 4);
        exp_wr(0, 2'd0, 4);
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k % 5 == 0) chk("rr_turn", 32'(bus.gnt), 32'd0);
            else chk("rr_gnt", 32'(bus.gnt), 32'd1 << (((k - 1) / 5) % 4));
        end
        bus.req = '0;

        // Early release of requester 1 with requester 0 pending.
        bus.d   = '0;
        bus.req = 4'b0011;
        set_d(1, 2'b01);
        set_d(0, 2'b11);
        gq.push_back(1);
        exp_wr(1, 2'b01, 1); exp_wr(1, 2'b10, 1);
        tick(); chk("e_gnt", 32'(bus.gnt), 32'b0010);
        tick(); set_d(1, 2'b10);
        tick(); bus.req = 4'b0001;
        tick();
        chk("e_rel_gnt", 32'(bus.gnt), 32'd0);
        chk("e_rel_qv", 32'(bus.q_valid), 32'd0);
        chk("e_rel_q", 32'(bus.q), 32'b10);
        gq.push_back(0);
        tick(); chk("e_next_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        tick(); chk("e_next_rel", 32'(bus.gnt), 32'd0);

        // Wrap-around: after requester 3, req 1001 serves 0 then 3.
        bus.req = 4'b1000;
        set_d(3, 2'b01);
        gq.push_back(3);
        exp_wr(3, 2'b01, 1);
        tick(); chk("w_gnt3", 32'(bus.gnt), 32'b1000);
        tick(); bus.req = 4'b0001;
        tick(); chk("w_rel3", 32'(bus.gnt), 32'd0);
        bus.req = 4'b1001;
        gq.push_back(0); gq.push_back(3);
        exp_wr(0, 2'b11, 4);
        tick(); chk("w_gnt0", 32'(bus.gnt), 32'b0001);
        repeat (4) tick();
        chk("w_turn", 32'(bus.gnt), 32'd0);
        tick(); chk("w_gnt3b", 32'(bus.gnt), 32'b1000);
        bus.req = '0;
        tick(); chk("w_rel3b", 32'(bus.gnt), 32'd0);

        // Idle hold: nothing moves without requests.
        repeat (20) begin
            tick();
            chk("i_gnt", 32'(bus.gnt), 32'd0);
            chk("i_qv", 32'(bus.q_valid), 32'd0);
        end
        chk("i_q", 32'(bus.q), 32'b11);
        chk("i_owner", 32'(bus.owner), 32'd3);

        chk("left_grants", 32'(gq.size()), 32'd0);
        chk("left_writes", 32'(wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
